controller_controller_out: RTL and testbench

Emulates a standard 8-button NES-style game controller toward a console: accepts button state updates over a valid/data strobe (fed from the network receive path), and answers the console's latch/pulse polling by shifting the held button bits out on an active-low serial data line. It is the responder counterpart of the controller reader on the remote side. It sits between the received-packet decoder and the console's controller port.

---
 rtl/controller_controller_out_if.sv | 30 +++
 rtl/controller_controller_out.sv | 124 ++++++++++++
 tb/tb_controller_controller_out.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/controller_controller_out_if.sv
// Button-update strobe, console pins and status for the controller responder.
interface controller_controller_out_if;
  logic        axiiv;
  logic [7:0]  axiid;
  logic        latch;
  logic        pulse;
  logic        data;
  logic [15:0] poll_count;
  logic        stale;

  modport master (
    output axiiv,
    output axiid,
    output latch,
    output pulse,
    input  data,
    input  poll_count,
    input  stale
  );

  modport slave (
    input  axiiv,
    input  axiid,
    input  latch,
    input  pulse,
    output data,
    output poll_count,
    output stale
  );
endinterface

// File: rtl/controller_controller_out.sv
// NES-style controller responder: holds received buttons and shifts them
// out active-low on the console's latch/pulse polling.
module controller_controller_out #(
  parameter int unsigned STALE_CYCLES = 5_000_000,
  parameter logic        FILL_BIT     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  controller_controller_out_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int CW = (STALE_CYCLES > 0) ?
                      $clog2(STALE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] STALE_MAX = CW'(STALE_CYCLES);
  localparam logic [CW-1:0] STALE_PRE = STALE_MAX - CW'(1);
  localparam bit STALE_EN = (STALE_CYCLES != 0);

  logic [2:0]    latch_q;
  logic [2:0]    pulse_q;
  logic          latch_s;
  logic          pulse_rise;

  logic [7:0]    held;
  logic [CW-1:0] stale_cnt;
  logic          stale_q;

  logic [1:0]    state;
  logic [7:0]    sr;
  logic [3:0]    idx;
  logic [15:0]   polls;
  logic          data_q;

  // Pins are asynchronous: two stages to settle, a third for the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latch_q <= '0;
      pulse_q <= '0;
    end else begin
      latch_q <= {latch_q[1:0], bus.latch};
      pulse_q <= {pulse_q[1:0], bus.pulse};
    end
  end

  assign latch_s    = latch_q[1];
  assign pulse_rise = pulse_q[1] & ~pulse_q[2];

  // A strobe always wins over an expiry landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held      <= '0;
      stale_cnt <= '0;
      stale_q   <= 1'b0;
    end else if (bus.axiiv) begin
      held      <= bus.axiid;
      stale_cnt <= '0;
      stale_q   <= 1'b0;
    end else if (STALE_EN && stale_cnt != STALE_MAX) begin
      stale_cnt <= stale_cnt + CW'(1);
      if (stale_cnt == STALE_PRE) begin
        held    <= '0;
        stale_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      sr     <= '0;
      idx    <= '0;
      polls  <= '0;
      data_q <= 1'b1;
    end else begin
      data_q <= ~sr[0];
      case (state)
        S_IDLE: begin
          if (latch_s) begin
            state <= S_LOAD;
            sr    <= held;
            idx   <= '0;
          end
        end
        S_LOAD: begin
          sr  <= held;
          idx <= '0;
          if (!latch_s) begin
            state <= S_SHIFT;
            polls <= polls + 16'd1;
          end
        end
        S_SHIFT: begin
          if (latch_s) begin
            state <= S_LOAD;
            sr    <= held;
            idx   <= '0;
          end else if (pulse_rise) begin
            sr  <= {FILL_BIT, sr[7:1]};
            idx <= (idx == 4'd8) ? idx : idx + 4'd1;
            if (idx == 4'd7)
              state <= S_DONE;
          end
        end
        S_DONE: begin
          if (latch_s) begin
            state <= S_LOAD;
            sr    <= held;
            idx   <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.data       = data_q;
  assign bus.poll_count = polls;
  assign bus.stale      = stale_q;

endmodule

// File: tb/tb_controller_controller_out.sv
// Directed bench: poll sequences, latch abort, mid-poll reset and stale timeout.
module tb_controller_controller_out;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;

  always #5 clk = ~clk;

  controller_controller_out_if bus_a ();
  controller_controller_out_if bus_b ();

  controller_controller_out #(
    .STALE_CYCLES(0),
    .FILL_BIT(1'b1)
  ) dut_a (
    .clk(clk),
    .rst(rst_a),
    .bus(bus_a)
  );

  controller_controller_out #(
    .STALE_CYCLES(100),
    .FILL_BIT(1'b1)
  ) dut_b (
    .clk(clk),
    .rst(rst_b),
    .bus(bus_b)
  );

  int vectors = 0;
  int miscompares = 0;
  int exp_polls = 0;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic exp_bit(input logic [7:0] btn, input int k);
    if (k >= 8) return 1'b0;
    return ~btn[k];
  endfunction

  function automatic logic rd_data(input bit sel);
    return sel ? bus_b.data : bus_a.data;
  endfunction

  function automatic logic [15:0] rd_polls(input bit sel);
    return sel ? bus_b.poll_count : bus_a.poll_count;
  endfunction

  task automatic set_latch(input bit sel, input logic v);
    if (sel) bus_b.latch = v;
    else     bus_a.latch = v;
  endtask

  task automatic set_pulse(input bit sel, input logic v);
    if (sel) bus_b.pulse = v;
    else     bus_a.pulse = v;
  endtask

  task automatic strobe(input bit sel, input logic [7:0] btn);
    if (sel) begin
      bus_b.axiid = btn;
      bus_b.axiiv = 1'b1;
    end else begin
      bus_a.axiid = btn;
      bus_a.axiiv = 1'b1;
    end
    wait_n(1);
    bus_a.axiiv = 1'b0;
    bus_b.axiiv = 1'b0;
  endtask

  // Pin rises at a negedge; data must still be old 3 negedges later, new at 4.
  task automatic pulse_chk(input bit sel, input logic pre,
                           input logic post, input string tag);
    set_pulse(sel, 1'b1);
    wait_n(3);
    chk({tag, "_pre"}, 16'(rd_data(sel)), 16'(pre));
    wait_n(1);
    chk(tag, 16'(rd_data(sel)), 16'(post));
    wait_n(2);
    set_pulse(sel, 1'b0);
    wait_n(6);
  endtask

  task automatic latch_poll(input bit sel, input logic [7:0] btn,
                            input int hold, input int polls_after);
    set_latch(sel, 1'b1);
    wait_n(4);
    chk("latch_a_bit", 16'(rd_data(sel)), 16'(exp_bit(btn, 0)));
    wait_n(hold - 4);
    set_latch(sel, 1'b0);
    wait_n(3);
    chk("poll_count", rd_polls(sel), 16'(polls_after));
    wait_n(3);
  endtask

  task automatic read_bits(input bit sel, input logic [7:0] btn,
                           input int first, input int last);
    for (int k = first; k <= last; k++)
      pulse_chk(sel, exp_bit(btn, k - 1), exp_bit(btn, k),
                $sformatf("bit%0d", k));
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.axiiv = 1'b0; bus_a.axiid = '0;
    bus_a.latch = 1'b0; bus_a.pulse = 1'b0;
    bus_b.axiiv = 1'b0; bus_b.axiid = '0;
    bus_b.latch = 1'b0; bus_b.pulse = 1'b0;
    wait_n(3);
    chk("rst_data", 16'(bus_a.data), 16'd1);
    chk("rst_polls", bus_a.poll_count, 16'd0);
    chk("rst_stale", 16'(bus_a.stale), 16'd0);
    rst_a = 1'b0;
    wait_n(2);

    // Main poll of 1000_0101 with exact latch timing
    strobe(1'b0, 8'b1000_0101);
    set_latch(1'b0, 1'b1);
    wait_n(3);
    chk("latch_lag", 16'(bus_a.data), 16'd1);
    wait_n(1);
    chk("latch_a", 16'(bus_a.data), 16'd0);
    wait_n(8);
    set_latch(1'b0, 1'b0);
    wait_n(3);
    exp_polls = 1;
    chk("poll1", bus_a.poll_count, 16'(exp_polls));
    chk("a_after_latch", 16'(bus_a.data), 16'd0);
    wait_n(3);
    read_bits(1'b0, 8'b1000_0101, 1, 8);
    read_bits(1'b0, 8'b1000_0101, 9, 12);
    chk("poll1_hold", bus_a.poll_count, 16'(exp_polls));

    // All-released poll
    strobe(1'b0, 8'h00);
    exp_polls++;
    latch_poll(1'b0, 8'h00, 12, exp_polls);
    read_bits(1'b0, 8'h00, 1, 8);

    // Update during latch: data follows two cycles after the strobe
    set_latch(1'b0, 1'b1);
    wait_n(6);
    chk("upd_before", 16'(bus_a.data), 16'd1);
    bus_a.axiid = 8'h01;
    bus_a.axiiv = 1'b1;
    wait_n(1);
    bus_a.axiiv = 1'b0;
    chk("upd_c1", 16'(bus_a.data), 16'd1);
    wait_n(1);
    chk("upd_c2_pre", 16'(bus_a.data), 16'd1);
    wait_n(1);
    chk("upd_c2", 16'(bus_a.data), 16'd0);
    set_latch(1'b0, 1'b0);
    wait_n(3);
    exp_polls++;
    chk("upd_polls", bus_a.poll_count, 16'(exp_polls));
    chk("upd_first", 16'(bus_a.data), 16'd0);
    wait_n(3);

    // Abort after 4 pulses with a fresh latch
    read_bits(1'b0, 8'h01, 1, 4);
    set_latch(1'b0, 1'b1);
    wait_n(3);
    chk("abort_pre", 16'(bus_a.data), 16'd1);
    wait_n(1);
    chk("abort_a", 16'(bus_a.data), 16'd0);
    wait_n(4);
    chk("abort_polls_held", bus_a.poll_count, 16'(exp_polls));
    set_latch(1'b0, 1'b0);
    wait_n(3);
    exp_polls++;
    chk("abort_polls", bus_a.poll_count, 16'(exp_polls));
    wait_n(3);
    read_bits(1'b0, 8'h01, 1, 8);

    // Reset in the middle of shifting
    strobe(1'b0, 8'b1000_0101);
    exp_polls++;
    latch_poll(1'b0, 8'b1000_0101, 12, exp_polls);
    read_bits(1'b0, 8'b1000_0101, 1, 3);
    rst_a = 1'b1;
    #1;
    chk("mid_rst_data", 16'(bus_a.data), 16'd1);
    chk("mid_rst_polls", bus_a.poll_count, 16'd0);
    chk("mid_rst_stale", 16'(bus_a.stale), 16'd0);
    wait_n(2);
    rst_a = 1'b0;
    wait_n(2);
    latch_poll(1'b0, 8'h00, 12, 1);
    read_bits(1'b0, 8'h00, 1, 8);
    chk("a_stale_off", 16'(bus_a.stale), 16'd0);

    // Stale timeout on the 100-cycle instance
    rst_b = 1'b0;
    bus_b.axiid = 8'hFF;
    bus_b.axiiv = 1'b1;
    wait_n(1);
    bus_b.axiiv = 1'b0;
    wait_n(99);
    chk("stale_c99", 16'(bus_b.stale), 16'd0);
    wait_n(1);
    chk("stale_c100", 16'(bus_b.stale), 16'd1);
    latch_poll(1'b1, 8'h00, 12, 1);
    read_bits(1'b1, 8'h00, 1, 8);
    chk("stale_kept", 16'(bus_b.stale), 16'd1);

    // Strobe coinciding with expiry
    strobe(1'b1, 8'h55);
    chk("stale_clr", 16'(bus_b.stale), 16'd0);
    wait_n(99);
    bus_b.axiid = 8'h02;
    bus_b.axiiv = 1'b1;
    wait_n(1);
    bus_b.axiiv = 1'b0;
    chk("collide_stale", 16'(bus_b.stale), 16'd0);
    latch_poll(1'b1, 8'h02, 6, 2);
    read_bits(1'b1, 8'h02, 1, 2);
    chk("collide_stale_end", 16'(bus_b.stale), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
